// File: rtl/uart_prog_loader_if.sv
// ============================================================================
//  Module      : uart_prog_loader_if
//  Description : Byte-in / word-write bus between UART RX, loader and memories.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_prog_loader_if #(
    parameter int ADDR_W = 17
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              wready;
    logic              mem_we;
    logic              imem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W-1:0] waddr;
    logic              done;
    logic              overrun;

    // master: the loader; slave: UART RX plus the memory side
    modport master (
        input  rx_valid, rx_data, wready,
        output mem_we, imem_we, mem_waddr, mem_wdata, waddr, done, overrun
    );

    modport slave (
        output rx_valid, rx_data, wready,
        input  mem_we, imem_we, mem_waddr, mem_wdata, waddr, done, overrun
    );
endinterface

`default_nettype wire

// File: rtl/uart_prog_loader.sv
// ============================================================================
//  Module      : uart_prog_loader
//  Description : Packs UART bytes into little-endian words and writes them to
//                DRAM (and the low IMEM_WORDS to imem); raises done when loaded.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_prog_loader #(
    parameter int IMAGE_WORDS = 131072,
    parameter int IMEM_WORDS  = 16384,
    parameter int ADDR_W      = 17
) (
    input  wire                     clk,
    input  wire                     rst,
    uart_prog_loader_if.master      bus
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(IMAGE_WORDS - 1);
    // Progress counter stops at IMAGE_WORDS, or at its all-ones value when
    // IMAGE_WORDS does not fit in ADDR_W bits.
    localparam int c_WADDR_MAX = (IMAGE_WORDS > ((2 ** ADDR_W) - 1)) ?
                                 ((2 ** ADDR_W) - 1) : IMAGE_WORDS;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [23:0]       r_shreg;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [31:0]       r_mem_wdata;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_done;
    logic              r_overrun;

    logic w_byte;
    logic w_commit;
    logic w_complete;
    logic w_accept;

    assign w_byte     = (r_state == S_LOAD) && bus.rx_valid;
    assign w_commit   = r_mem_we && bus.wready;
    assign w_complete = w_byte && (r_cnt == 2'd3);
    // A commit in the same cycle frees the slot, so the new word is taken.
    assign w_accept   = w_complete && (!r_mem_we || w_commit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_LOAD;
            r_cnt       <= 2'd0;
            r_shreg     <= 24'd0;
            r_next_addr <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= 32'd0;
            r_waddr     <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_byte) begin
                case (r_cnt)
                    2'd0:    r_shreg[7:0]   <= bus.rx_data;
                    2'd1:    r_shreg[15:8]  <= bus.rx_data;
                    2'd2:    r_shreg[23:16] <= bus.rx_data;
                    default: ;
                endcase
                r_cnt <= r_cnt + 2'd1;
            end

            if (w_commit) begin
                r_mem_we <= 1'b0;
                if (32'(r_waddr) < c_WADDR_MAX) begin
                    r_waddr <= r_waddr + ADDR_W'(1);
                end
            end

            if (w_accept) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= {bus.rx_data, r_shreg};
                r_mem_waddr <= r_next_addr;
                r_next_addr <= r_next_addr + ADDR_W'(1);
                if (r_next_addr == c_LAST_ADDR) begin
                    r_state <= S_FLUSH;
                end
            end else if (w_complete) begin
                r_overrun <= 1'b1;
            end

            if ((r_state == S_FLUSH) && w_commit) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
            end
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.imem_we   = w_commit && (32'(r_mem_waddr) < IMEM_WORDS);
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.waddr     = r_waddr;
    assign bus.done      = r_done;
    assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
// ============================================================================
//  Module      : tb_uart_prog_loader
//  Description : Directed self-checking bench for uart_prog_loader (8-word image).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    int mon_commits = 0;
    int mon_imem    = 0;
    int mon_imem_hi = 0;
    int mon_we      = 0;

    uart_prog_loader_if #(.ADDR_W(4)) bus ();

    uart_prog_loader #(
        .IMAGE_WORDS (8),
        .IMEM_WORDS  (4),
        .ADDR_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Write-side activity, sampled mid-cycle while inputs are stable
    always @(negedge clk) begin
        if (bus.mem_we) mon_we++;
        if (bus.mem_we && bus.wready) mon_commits++;
        if (bus.imem_we) begin
            mon_imem++;
            if (bus.mem_waddr >= 4'd4) mon_imem_hi++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    int c0, i0, h0, w0;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.wready   = 1'b0;
        tick();
        do_reset();
        check_val("rst_mem_we",  32'(bus.mem_we),    32'd0);
        check_val("rst_waddr",   32'(bus.waddr),     32'd0);
        check_val("rst_wdata",   bus.mem_wdata,      32'd0);
        check_val("rst_done",    32'(bus.done),      32'd0);
        check_val("rst_overrun", 32'(bus.overrun),   32'd0);

        // 1: single word, immediate commit
        bus.wready = 1'b1;
        send_word(32'h0000_0013);
        check_val("t1_mem_we",  32'(bus.mem_we),    32'd1);
        check_val("t1_addr",    32'(bus.mem_waddr), 32'd0);
        check_val("t1_data",    bus.mem_wdata,      32'h0000_0013);
        check_val("t1_imem_we", 32'(bus.imem_we),   32'd1);
        tick();
        check_val("t1_waddr",   32'(bus.waddr),     32'd1);
        check_val("t1_we_off",  32'(bus.mem_we),    32'd0);

        // 2: backpressure for 5 clocks keeps the write stable
        bus.wready = 1'b0;
        send_word(32'h4433_2211);
        for (int i = 0; i < 5; i++) begin
            check_val("t2_hold_we",   32'(bus.mem_we),    32'd1);
            check_val("t2_hold_addr", 32'(bus.mem_waddr), 32'd1);
            check_val("t2_hold_data", bus.mem_wdata,      32'h4433_2211);
            check_val("t2_hold_imem", 32'(bus.imem_we),   32'd0);
            tick();
        end
        bus.wready = 1'b1;
        #1;
        check_val("t2_imem_we", 32'(bus.imem_we), 32'd1);
        tick();
        check_val("t2_we_off",  32'(bus.mem_we),  32'd0);
        check_val("t2_waddr",   32'(bus.waddr),   32'd2);
        check_val("t2_overrun", 32'(bus.overrun), 32'd0);

        // 6: 4th byte strobe coincides with the previous word's commit
        bus.wready = 1'b0;
        send_word(32'h2423_2221);
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        bus.wready = 1'b1;
        send_byte(8'h34);
        check_val("t6_waddr",   32'(bus.waddr),     32'd3);
        check_val("t6_mem_we",  32'(bus.mem_we),    32'd1);
        check_val("t6_addr",    32'(bus.mem_waddr), 32'd3);
        check_val("t6_data",    bus.mem_wdata,      32'h3433_3231);
        check_val("t6_overrun", 32'(bus.overrun),   32'd0);
        check_val("t6_imem3",   32'(bus.imem_we),   32'd1);
        tick();
        check_val("t6_waddr2",  32'(bus.waddr),     32'd4);

        // 3: overrun while a write is pending
        bus.wready = 1'b0;
        send_word(32'h4443_4241);
        send_word(32'h0403_0201);
        check_val("t3_overrun", 32'(bus.overrun),   32'd1);
        check_val("t3_data",    bus.mem_wdata,      32'h4443_4241);
        check_val("t3_addr",    32'(bus.mem_waddr), 32'd4);
        check_val("t3_waddr",   32'(bus.waddr),     32'd4);
        bus.wready = 1'b1;
        #1;
        check_val("t3_imem_bnd", 32'(bus.imem_we), 32'd0);
        tick();
        check_val("t3_waddr2",  32'(bus.waddr),  32'd5);
        check_val("t3_we_off",  32'(bus.mem_we), 32'd0);
        send_word(32'h5453_5251);
        check_val("t3_next_addr", 32'(bus.mem_waddr), 32'd5);
        check_val("t3_next_data", bus.mem_wdata,      32'h5453_5251);

        // 4: full 8-word image, imem mirror only below 4, then done
        do_reset();
        bus.wready = 1'b1;
        c0 = mon_commits;
        i0 = mon_imem;
        h0 = mon_imem_hi;
        for (int k = 0; k < 32; k++) send_byte(8'(k + 1));
        check_val("t4_last_addr", 32'(bus.mem_waddr), 32'd7);
        check_val("t4_last_data", bus.mem_wdata,      32'h201F_1E1D);
        check_val("t4_done_pre",  32'(bus.done),      32'd0);
        tick();
        check_val("t4_done",      32'(bus.done),      32'd1);
        check_val("t4_waddr",     32'(bus.waddr),     32'd8);
        check_val("t4_we_off",    32'(bus.mem_we),    32'd0);
        check_val("t4_commits",   32'(mon_commits - c0), 32'd8);
        check_val("t4_imem_cnt",  32'(mon_imem - i0),    32'd4);
        check_val("t4_imem_hi",   32'(mon_imem_hi - h0), 32'd0);
        w0 = mon_we;
        for (int k = 0; k < 8; k++) send_byte(8'hE0 + 8'(k));
        tick();
        check_val("t4_no_we",     32'(mon_we - w0),   32'd0);
        check_val("t4_done_hold", 32'(bus.done),      32'd1);
        check_val("t4_waddr_sat", 32'(bus.waddr),     32'd8);

        // 5: reset mid-load discards pending and partial data
        do_reset();
        bus.wready = 1'b0;
        for (int k = 0; k < 6; k++) send_byte(8'h60 + 8'(k));
        check_val("t5_pending", 32'(bus.mem_we), 32'd1);
        do_reset();
        check_val("t5_rst_we",  32'(bus.mem_we), 32'd0);
        bus.wready = 1'b1;
        send_word(32'hDDCC_BBAA);
        check_val("t5_mem_we", 32'(bus.mem_we),    32'd1);
        check_val("t5_addr",   32'(bus.mem_waddr), 32'd0);
        check_val("t5_data",   bus.mem_wdata,      32'hDDCC_BBAA);
        tick();

        // Trailing partial word is never written
        w0 = mon_we;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        for (int i = 0; i < 4; i++) tick();
        check_val("partial_no_we", 32'(mon_we - w0), 32'd0);
        check_val("partial_waddr", 32'(bus.waddr),   32'd1);
        check_val("partial_done",  32'(bus.done),    32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
